router_pkt_reg: RTL and testbench
=================================

ROUTER_PKT_REG -- requirements
Module: router_pkt_reg

Interface
REQ-001 Parameter DATA_W, default 8: data and parity byte width, minimum 8.
REQ-002 Parameter SKID_DEPTH, default 4: words held while the downstream FIFO is full, 1..16.
REQ-003 Parameter PARITY_ODD, default 0: 0 = even XOR parity, 1 = odd (internal result inverted before compare).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 pkt_valid  in  1  packet in progress; falls with the parity word.
REQ-007 din  in  DATA_W  header/payload/parity word; din[1:0] = destination address.
REQ-008 fifo_full  in  1  selected downstream FIFO full.
REQ-009 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  in  1 each  FSM state strobes.
REQ-010 dout  out  DATA_W  word to the downstream FIFO.
REQ-011 dout_vld  out  1  one-cycle pulse each cycle dout is loaded.
REQ-012 err  out  1  parity mismatch.
REQ-013 parity_done  out  1  parity check complete.
REQ-014 low_pkt_valid  out  1  parity word received.
REQ-015 skid_empty  out  1  skid buffer holds no words.
REQ-016 skid_ovf  out  1  sticky: a word was dropped on a full skid buffer.

Function
REQ-017 detect_add && pkt_valid && din[1:0]!=2'b11 shall capture din into the header register and clear the internal parity, parity_done, err and skid_ovf.
REQ-018 Strobe priority shall be lfd_state > laf_state > ld_state; simultaneous lower strobes are ignored.
REQ-019 lfd_state shall load dout with the header, pulse dout_vld, and XOR the header into internal parity.
REQ-020 ld_state && !fifo_full shall load dout with din and pulse dout_vld.
REQ-021 ld_state && fifo_full shall push din into the skid buffer; if the buffer is already full, din is dropped and skid_ovf set.
REQ-022 laf_state with skid not empty shall pop the oldest word to dout with dout_vld, one word per cycle, FIFO order; laf_state on empty shall leave dout unchanged with no pulse.
REQ-023 Internal parity shall XOR din when ld_state && pkt_valid && !full_state, regardless of fifo_full.
REQ-024 ld_state && !pkt_valid shall set low_pkt_valid and latch din as the packet parity, whether or not it is also pushed to skid.
REQ-025 parity_done shall set on ld_state && !pkt_valid && !fifo_full, or on laf_state && low_pkt_valid when the skid buffer is empty or this cycle pops its last word.
REQ-026 err shall be evaluated in the cycle after parity_done rises: err = (internal parity ^ {DATA_W{PARITY_ODD}}) != packet parity; held until the next header capture.
REQ-027 rst_int_reg shall clear low_pkt_valid only; the skid buffer is never flushed by it.
REQ-028 Skid pointers shall wrap modulo SKID_DEPTH; a push and pop in the same cycle are impossible by REQ-018.

Reset
REQ-029 reset shall immediately clear dout, header, internal and packet parity, skid pointers and count, and all flags, leaving skid_empty=1 and every other output 0.
REQ-030 reset asserted mid-packet shall discard all buffered words; after release, the block waits for detect_add.

Structure
REQ-031 Package router_pkg shall hold ADDR_INVALID (2'b11), the DATA_W default, and PARITY_EVEN/PARITY_ODD constants.
REQ-032 Skid storage shall be a sub-module router_skid_fifo (push, pop, data, empty, full, count), parametrised by DATA_W and SKID_DEPTH.

Verification
REQ-033 Header 0x05, payload 0x07, 0x08, 0x02, parity 0x08, fifo_full=0 -> dout 05,07,08,02; parity_done=1; err=0.
REQ-034 Same packet with parity 0x09 -> err=1 one cycle after parity_done; err is cleared by the next valid detect_add.
REQ-035 fifo_full=1 during payloads 0x11, 0x22, 0x33 (SKID_DEPTH=4), then laf_state -> dout 11,22,33 on consecutive cycles; skid_empty=1 afterwards.
REQ-036 SKID_DEPTH=2, three words pushed while full -> skid_ovf=1; only the first two are drained.
REQ-037 PARITY_ODD=1, header 0x01, payload 0x01, parity 0xFF -> err=0; detect_add with din=0x03 -> header unchanged.
REQ-038 reset asserted with two words in skid -> skid_empty=1 and dout=0 immediately; a following laf_state gives no dout_vld.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the router packet register and its skid buffer.
package router_pkg;

  // Destination address that no output port answers to.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Default width of data and parity words.
  localparam int DATA_W_DEFAULT = 8;

  // Parity sense selectors.
  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/router_skid_fifo.sv
// Small circular FIFO that holds payload words while the downstream FIFO is full.
module router_skid_fifo
  import router_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEFAULT,
  parameter  int SKID_DEPTH = 4,
  localparam int PTR_W      = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1,
  localparam int CNT_W      = $clog2(SKID_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(SKID_DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign data    = mem[rd_ptr];

  // Storage write; the word under rd_ptr is always presented on data.
  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap modulo the depth; count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_reg.sv
// Router packet register: header hold, payload forwarding with a skid buffer,
// and running parity check against the trailing parity word.
module router_pkt_reg
  import router_pkg::ADDR_INVALID, router_pkg::DATA_W_DEFAULT, router_pkg::PARITY_EVEN;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int SKID_DEPTH = 4,
  parameter int PARITY_ODD = PARITY_EVEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              err,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              skid_empty,
  output logic              skid_ovf
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [DATA_W-1:0] PAR_MASK = (PARITY_ODD != 0) ? '1 : '0;

  logic [DATA_W-1:0] header;
  logic [DATA_W-1:0] int_parity;
  logic [DATA_W-1:0] pkt_parity;
  logic              parity_done_q;
  logic              hdr_cap;
  logic              do_lfd;
  logic              do_laf;
  logic              do_ld;
  logic              skid_push;
  logic              skid_pop;
  logic              skid_full;
  logic              last_pop;
  logic [DATA_W-1:0] skid_data;
  logic [CNT_W-1:0]  skid_count;

  // Strobe decode: lfd beats laf beats ld, so push and pop never coincide.
  assign hdr_cap   = detect_add && pkt_valid && (din[1:0] != ADDR_INVALID);
  assign do_lfd    = lfd_state;
  assign do_laf    = laf_state && !lfd_state;
  assign do_ld     = ld_state && !lfd_state && !laf_state;
  assign skid_push = do_ld && fifo_full;
  assign skid_pop  = do_laf && !skid_empty;
  assign last_pop  = skid_empty || (skid_count == CNT_W'(1));

  router_skid_fifo #(
    .DATA_W     (DATA_W),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_data (din),
    .data      (skid_data),
    .empty     (skid_empty),
    .full      (skid_full),
    .count     (skid_count)
  );

  // Header register: only a header for a real destination is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        header <= '0;
    else if (hdr_cap) header <= din;
  end

  // Output word and its one-cycle valid pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      if (do_lfd) begin
        dout     <= header;
        dout_vld <= 1'b1;
      end else if (skid_pop) begin
        dout     <= skid_data;
        dout_vld <= 1'b1;
      end else if (do_ld && !fifo_full) begin
        dout     <= din;
        dout_vld <= 1'b1;
      end
    end
  end

  // Parity accumulation, completion, error and overflow flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_parity    <= '0;
      parity_done   <= 1'b0;
      parity_done_q <= 1'b0;
      err           <= 1'b0;
      skid_ovf      <= 1'b0;
    end else begin
      parity_done_q <= parity_done;
      if (hdr_cap) begin
        int_parity  <= '0;
        parity_done <= 1'b0;
        err         <= 1'b0;
        skid_ovf    <= 1'b0;
      end else begin
        if (do_lfd)
          int_parity <= int_parity ^ header;
        else if (do_ld && pkt_valid && !full_state)
          int_parity <= int_parity ^ din;
        if (skid_push && skid_full)
          skid_ovf <= 1'b1;
        if ((do_ld && !pkt_valid && !fifo_full) || (do_laf && low_pkt_valid && last_pop))
          parity_done <= 1'b1;
        // Compare one cycle after completion so the final accumulation has settled.
        if (parity_done && !parity_done_q)
          err <= ((int_parity ^ PAR_MASK) != pkt_parity);
      end
    end
  end

  // Parity word capture; rst_int_reg is the only thing that re-arms it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_pkt_valid <= 1'b0;
      pkt_parity    <= '0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (do_ld && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
      pkt_parity    <= din;
    end
  end

endmodule

// File: tb/tb_router_pkt_reg.sv
// Directed bench for router_pkt_reg: three instances share stimulus
// (defaults, SKID_DEPTH=2, PARITY_ODD=1); each check targets one instance.
module tb_router_pkt_reg;

  // Strobe vector bits: {detect_add, lfd, ld, laf, full_state, rst_int_reg}
  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] DA   = 6'b100000;
  localparam logic [5:0] LFD  = 6'b010000;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] LAF  = 6'b000100;
  localparam logic [5:0] RIR  = 6'b000001;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid, fifo_full;
  logic [7:0] din;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;

  logic [7:0] dout [3];
  logic       dout_vld [3];
  logic       err [3];
  logic       parity_done [3];
  logic       low_pkt_valid [3];
  logic       skid_empty [3];
  logic       skid_ovf [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  router_pkt_reg u0 (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout[0]), .dout_vld(dout_vld[0]), .err(err[0]), .parity_done(parity_done[0]),
    .low_pkt_valid(low_pkt_valid[0]), .skid_empty(skid_empty[0]), .skid_ovf(skid_ovf[0])
  );

  router_pkt_reg #(.SKID_DEPTH(2)) u1 (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout[1]), .dout_vld(dout_vld[1]), .err(err[1]), .parity_done(parity_done[1]),
    .low_pkt_valid(low_pkt_valid[1]), .skid_empty(skid_empty[1]), .skid_ovf(skid_ovf[1])
  );

  router_pkt_reg #(.PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout[2]), .dout_vld(dout_vld[2]), .err(err[2]), .parity_done(parity_done[2]),
    .low_pkt_valid(low_pkt_valid[2]), .skid_empty(skid_empty[2]), .skid_ovf(skid_ovf[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus; outputs are sampled 1 ns after the edge.
  task automatic step(input logic [5:0] s, input logic pv, input logic [7:0] d, input logic ff);
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = s;
    pkt_valid = pv;
    din       = d;
    fifo_full = ff;
    @(posedge clk);
    #1;
  endtask

  // Header 0x05, payload 07 08 02 (expected internal parity 0x08), then the given parity word.
  task automatic send_basic(input logic [7:0] par, input logic exp_err);
    logic [7:0] pay [3];
    pay = '{8'h07, 8'h08, 8'h02};
    step(DA, 1'b1, 8'h05, 1'b0);
    check("hdr_clears_done", 32'(parity_done[0]), 0);
    check("hdr_clears_err", 32'(err[0]), 0);
    step(LFD, 1'b1, 8'h05, 1'b0);
    check("lfd_dout", 32'(dout[0]), 32'h05);
    check("lfd_vld", 32'(dout_vld[0]), 1);
    for (int i = 0; i < 3; i++) begin
      step(LD, 1'b1, pay[i], 1'b0);
      check($sformatf("pay%0d_dout", i), 32'(dout[0]), 32'(pay[i]));
      check($sformatf("pay%0d_vld", i), 32'(dout_vld[0]), 1);
    end
    step(LD, 1'b0, par, 1'b0);
    check("par_done", 32'(parity_done[0]), 1);
    check("par_lpv", 32'(low_pkt_valid[0]), 1);
    check("par_err_not_yet", 32'(err[0]), 0);
    check("par_dout", 32'(dout[0]), 32'(par));
    step(IDLE, 1'b0, 8'h00, 1'b0);
    check("err_eval", 32'(err[0]), 32'(exp_err));
    check("idle_no_vld", 32'(dout_vld[0]), 0);
    step(RIR, 1'b0, 8'h00, 1'b0);
    check("rir_clears_lpv", 32'(low_pkt_valid[0]), 0);
    check("rir_keeps_err", 32'(err[0]), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] drain [4];
    drain = '{8'h11, 8'h22, 8'h33, 8'h0A};

    reset = 1'b1;
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = IDLE;
    pkt_valid = 1'b0;
    din       = 8'h00;
    fifo_full = 1'b0;
    #2;
    check("rst_dout", 32'(dout[0]), 0);
    check("rst_vld", 32'(dout_vld[0]), 0);
    check("rst_skid_empty", 32'(skid_empty[0]), 1);
    check("rst_err", 32'(err[0]), 0);
    check("rst_done", 32'(parity_done[0]), 0);
    check("rst_lpv", 32'(low_pkt_valid[0]), 0);
    check("rst_ovf", 32'(skid_ovf[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Good parity, then bad parity (0x09 vs computed 0x08).
    send_basic(8'h08, 1'b0);
    send_basic(8'h09, 1'b1);

    // Next valid header clears err; payloads pile up in skid while full.
    step(DA, 1'b1, 8'h0A, 1'b0);
    check("new_hdr_clears_err", 32'(err[0]), 0);
    step(LFD, 1'b1, 8'h0A, 1'b0);
    check("hdr0A_dout", 32'(dout[0]), 32'h0A);
    for (int i = 0; i < 3; i++) begin
      step(LD, 1'b1, drain[i], 1'b1);
      check($sformatf("push%0d_no_vld", i), 32'(dout_vld[0]), 0);
      check($sformatf("push%0d_dout_held", i), 32'(dout[0]), 32'h0A);
    end
    check("skid_not_empty", 32'(skid_empty[0]), 0);
    check("d4_no_ovf", 32'(skid_ovf[0]), 0);
    check("d2_ovf", 32'(skid_ovf[1]), 1);
    // Parity 0x0A = 0A^11^22^33, also pushed while full.
    step(LD, 1'b0, 8'h0A, 1'b1);
    check("full_par_no_done", 32'(parity_done[0]), 0);
    check("full_par_lpv", 32'(low_pkt_valid[0]), 1);
    for (int i = 0; i < 4; i++) begin
      step(LAF, 1'b0, 8'h00, 1'b0);
      check($sformatf("pop%0d_dout", i), 32'(dout[0]), 32'(drain[i]));
      check($sformatf("pop%0d_vld", i), 32'(dout_vld[0]), 1);
      if (i < 2) begin
        check($sformatf("d2_pop%0d_dout", i), 32'(dout[1]), 32'(drain[i]));
        check($sformatf("d2_pop%0d_vld", i), 32'(dout_vld[1]), 1);
      end else if (i == 2) begin
        check("d2_pop2_no_vld", 32'(dout_vld[1]), 0);
        check("d2_pop2_dout_held", 32'(dout[1]), 32'h22);
      end
    end
    check("last_pop_done", 32'(parity_done[0]), 1);
    step(IDLE, 1'b0, 8'h00, 1'b0);
    check("drain_err", 32'(err[0]), 0);
    check("drain_skid_empty", 32'(skid_empty[0]), 1);
    step(LAF, 1'b0, 8'h00, 1'b0);
    check("laf_empty_no_vld", 32'(dout_vld[0]), 0);
    check("laf_empty_dout_held", 32'(dout[0]), 32'h0A);
    step(RIR, 1'b0, 8'h00, 1'b0);

    // Odd parity: 01^01 = 00, inverted FF, matches parity word FF.
    step(DA, 1'b1, 8'h01, 1'b0);
    step(LFD, 1'b1, 8'h01, 1'b0);
    step(LD, 1'b1, 8'h01, 1'b0);
    step(LD, 1'b0, 8'hFF, 1'b0);
    step(IDLE, 1'b0, 8'h00, 1'b0);
    check("odd_err", 32'(err[2]), 0);
    check("even_same_pkt_err", 32'(err[0]), 1);
    step(RIR, 1'b0, 8'h00, 1'b0);
    step(DA, 1'b1, 8'h03, 1'b0);
    check("bad_addr_keeps_err", 32'(err[0]), 1);
    step(LFD, 1'b1, 8'h03, 1'b0);
    check("bad_addr_hdr_kept", 32'(dout[2]), 32'h01);

    // Reset with two words sitting in the skid buffer.
    step(DA, 1'b1, 8'h06, 1'b0);
    step(LFD, 1'b1, 8'h06, 1'b0);
    step(LD, 1'b1, 8'h44, 1'b1);
    step(LD, 1'b1, 8'h55, 1'b1);
    check("pre_rst_skid", 32'(skid_empty[0]), 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_skid_empty", 32'(skid_empty[0]), 1);
    check("async_rst_dout", 32'(dout[0]), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(LAF, 1'b0, 8'h00, 1'b0);
    check("post_rst_laf_no_vld", 32'(dout_vld[0]), 0);
    check("post_rst_laf_dout", 32'(dout[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
